// File: rtl/spo2_ratio_calc_pkg.sv
// Shared constants and state encoding for the SpO2 ratio-of-ratios block.
package spo2_ratio_calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_PRODUCT,
    ST_DIVIDE,
    ST_DONE
  } state_t;

  localparam int DEF_WIN_LOG2 = 7;
  localparam int DEF_MIN_AC   = 4;
  localparam int FRAC_BITS    = 8;
  localparam int DVD_W        = 24;
  localparam int DVS_W        = 16;
  localparam logic [15:0] RATIO_SAT = 16'hFFFF;

endpackage

// File: rtl/spo2_ratio_calc_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done is high on the 24th cycle after start.
module seq_divider
  import spo2_ratio_calc_pkg::*;
(
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  logic [DVD_W-1:0] quo_q, quo_d, src_quo;
  logic [DVS_W-1:0] rem_q, rem_d, src_rem, dvs_q, dvs_d;
  logic [DVS_W:0]   trial;
  logic [4:0]       cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    dvs_d   = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[DVD_W-1]};
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (start || run_q) begin
      if (trial >= {1'b0, dvs_d}) begin
        rem_d = DVS_W'(trial - {1'b0, dvs_d});
        quo_d = {src_quo[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {src_quo[DVD_W-2:0], 1'b0};
      end
    end
    if (start) begin
      cnt_d = 5'(DVD_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/spo2_ratio_calc.sv
// Windowed RED/IR peak-to-peak and mean extraction, beat counting, and the
// Q8.8 ratio R = (AC_red*DC_ir)/(AC_ir*DC_red) for pulse-oximetry.
module spo2_ratio_calc
  import spo2_ratio_calc_pkg::*;
#(
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int MIN_AC   = DEF_MIN_AC
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [7:0]  red_sample,
  input  logic [7:0]  ir_sample,
  output logic [15:0] ratio,
  output logic        ratio_valid,
  output logic [7:0]  ac_red,
  output logic [7:0]  ac_ir,
  output logic [7:0]  dc_red,
  output logic [7:0]  dc_ir,
  output logic [3:0]  beat_count,
  output logic        error,
  output logic        busy
);

  localparam int SUM_W = 8 + WIN_LOG2;
  localparam logic [7:0] MIN_AC_C = 8'(MIN_AC);
  localparam logic [7:0] THR_INIT = 8'd128;

  function automatic logic [15:0] sat_ratio(input logic [DVD_W-1:0] q);
    return (q[DVD_W-1:16] != '0) ? RATIO_SAT : q[15:0];
  endfunction

  state_t              state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_red_q, sum_red_d, sum_ir_q, sum_ir_d;
  logic [7:0]          min_red_q, min_red_d, max_red_q, max_red_d;
  logic [7:0]          min_ir_q, min_ir_d, max_ir_q, max_ir_d;
  logic [7:0]          prev_ir_q, prev_ir_d, thr_q, thr_d;
  logic                have_prev_q, have_prev_d;
  logic [3:0]          beats_q, beats_d;
  logic [15:0]         ratio_q, ratio_d;
  logic [7:0]          ac_red_q, ac_red_d, ac_ir_q, ac_ir_d;
  logic [7:0]          dc_red_q, dc_red_d, dc_ir_q, dc_ir_d;
  logic [3:0]          beat_count_q, beat_count_d;
  logic                error_q, error_d, ratio_valid_q, ratio_valid_d;

  logic [7:0]          ac_red_c, ac_ir_c, dc_red_c, dc_ir_c;
  logic [15:0]         num_c, den_c;
  logic [DVD_W-1:0]    dividend_c, quotient;
  logic                bad_c, div_start, div_done, publish, pub_err, clear;

  // window statistics, valid once the last sample of the window is in
  always_comb begin
    ac_red_c   = max_red_q - min_red_q;
    ac_ir_c    = max_ir_q - min_ir_q;
    dc_red_c   = 8'(sum_red_q >> WIN_LOG2);
    dc_ir_c    = 8'(sum_ir_q >> WIN_LOG2);
    num_c      = {8'd0, ac_red_c} * {8'd0, dc_ir_c};
    den_c      = {8'd0, ac_ir_c} * {8'd0, dc_red_c};
    bad_c      = (ac_red_c < MIN_AC_C) || (ac_ir_c < MIN_AC_C) || (den_c == 16'd0);
    dividend_c = {8'd0, num_c} << FRAC_BITS;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sum_red_d    = sum_red_q;
    sum_ir_d     = sum_ir_q;
    min_red_d    = min_red_q;
    max_red_d    = max_red_q;
    min_ir_d     = min_ir_q;
    max_ir_d     = max_ir_q;
    prev_ir_d    = prev_ir_q;
    have_prev_d  = have_prev_q;
    beats_d      = beats_q;
    thr_d        = thr_q;
    ratio_d      = ratio_q;
    ac_red_d     = ac_red_q;
    ac_ir_d      = ac_ir_q;
    dc_red_d     = dc_red_q;
    dc_ir_d      = dc_ir_q;
    beat_count_d = beat_count_q;
    error_d      = error_q;
    ratio_valid_d = 1'b0;
    div_start    = 1'b0;
    publish      = 1'b0;
    pub_err      = 1'b0;
    clear        = 1'b0;

    case (state_q)
      ST_IDLE: if (enable) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (sample_valid) begin
          sum_red_d = sum_red_q + SUM_W'(red_sample);
          sum_ir_d  = sum_ir_q + SUM_W'(ir_sample);
          if (red_sample < min_red_q) min_red_d = red_sample;
          if (red_sample > max_red_q) max_red_d = red_sample;
          if (ir_sample < min_ir_q)   min_ir_d  = ir_sample;
          if (ir_sample > max_ir_q)   max_ir_d  = ir_sample;
          if (have_prev_q && (prev_ir_q < thr_q) && (ir_sample >= thr_q) &&
              (beats_q != 4'hF))
            beats_d = beats_q + 4'd1;
          prev_ir_d   = ir_sample;
          have_prev_d = 1'b1;
          cnt_d       = cnt_q + WIN_LOG2'(1);
          if (&cnt_q) state_d = ST_PRODUCT;
        end
      end
      ST_PRODUCT: begin
        if (bad_c) begin
          publish = 1'b1;
          pub_err = 1'b1;
          state_d = ST_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          publish = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        clear   = 1'b1;
        state_d = ST_ACCUM;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d   = ST_IDLE;
      clear     = 1'b1;
      publish   = 1'b0;
      div_start = 1'b0;
      thr_d     = THR_INIT;
    end

    // results become visible together with the strobe
    if (publish) begin
      ratio_d       = pub_err ? RATIO_SAT : sat_ratio(quotient);
      error_d       = pub_err;
      ac_red_d      = ac_red_c;
      ac_ir_d       = ac_ir_c;
      dc_red_d      = dc_red_c;
      dc_ir_d       = dc_ir_c;
      beat_count_d  = beats_q;
      thr_d         = dc_ir_c;
      ratio_valid_d = 1'b1;
    end

    if (clear) begin
      cnt_d       = '0;
      sum_red_d   = '0;
      sum_ir_d    = '0;
      min_red_d   = 8'hFF;
      max_red_d   = 8'h00;
      min_ir_d    = 8'hFF;
      max_ir_d    = 8'h00;
      prev_ir_d   = 8'h00;
      have_prev_d = 1'b0;
      beats_d     = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sum_red_q     <= '0;
      sum_ir_q      <= '0;
      min_red_q     <= 8'hFF;
      max_red_q     <= 8'h00;
      min_ir_q      <= 8'hFF;
      max_ir_q      <= 8'h00;
      prev_ir_q     <= 8'h00;
      have_prev_q   <= 1'b0;
      beats_q       <= 4'd0;
      thr_q         <= THR_INIT;
      ratio_q       <= 16'd0;
      ac_red_q      <= 8'd0;
      ac_ir_q       <= 8'd0;
      dc_red_q      <= 8'd0;
      dc_ir_q       <= 8'd0;
      beat_count_q  <= 4'd0;
      error_q       <= 1'b0;
      ratio_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sum_red_q     <= sum_red_d;
      sum_ir_q      <= sum_ir_d;
      min_red_q     <= min_red_d;
      max_red_q     <= max_red_d;
      min_ir_q      <= min_ir_d;
      max_ir_q      <= max_ir_d;
      prev_ir_q     <= prev_ir_d;
      have_prev_q   <= have_prev_d;
      beats_q       <= beats_d;
      thr_q         <= thr_d;
      ratio_q       <= ratio_d;
      ac_red_q      <= ac_red_d;
      ac_ir_q       <= ac_ir_d;
      dc_red_q      <= dc_red_d;
      dc_ir_q       <= dc_ir_d;
      beat_count_q  <= beat_count_d;
      error_q       <= error_d;
      ratio_valid_q <= ratio_valid_d;
    end
  end

  seq_divider u_div (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend_c),
    .divisor  (den_c),
    .quotient (quotient),
    .done     (div_done)
  );

  assign ratio       = ratio_q;
  assign ratio_valid = ratio_valid_q;
  assign ac_red      = ac_red_q;
  assign ac_ir       = ac_ir_q;
  assign dc_red      = dc_red_q;
  assign dc_ir       = dc_ir_q;
  assign beat_count  = beat_count_q;
  assign error       = error_q;
  assign busy        = (state_q == ST_PRODUCT) || (state_q == ST_DIVIDE) ||
                       (state_q == ST_DONE);

endmodule

// File: tb/tb_spo2_ratio_calc.sv
// Scoreboard bench for spo2_ratio_calc: expected window results are queued
// as each window is driven and compared when ratio_valid strobes.
module tb_spo2_ratio_calc;

  logic        CLK = 1'b0;
  logic        rst_n, enable, sample_valid;
  logic [7:0]  red_sample, ir_sample;
  logic [15:0] ratio;
  logic        ratio_valid, error, busy;
  logic [7:0]  ac_red, ac_ir, dc_red, dc_ir;
  logic [3:0]  beat_count;

  typedef struct {
    logic [15:0] ratio;
    logic [7:0]  acr, dcr, aci, dci;
    logic [3:0]  beats;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  spo2_ratio_calc dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .red_sample   (red_sample),
    .ir_sample    (ir_sample),
    .ratio        (ratio),
    .ratio_valid  (ratio_valid),
    .ac_red       (ac_red),
    .ac_ir        (ac_ir),
    .dc_red       (dc_red),
    .dc_ir        (dc_ir),
    .beat_count   (beat_count),
    .error        (error),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (ratio_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check_eq("ratio",      32'(ratio),      32'(mon_e.ratio));
        check_eq("ac_red",     32'(ac_red),     32'(mon_e.acr));
        check_eq("dc_red",     32'(dc_red),     32'(mon_e.dcr));
        check_eq("ac_ir",      32'(ac_ir),      32'(mon_e.aci));
        check_eq("dc_ir",      32'(dc_ir),      32'(mon_e.dci));
        check_eq("beat_count", 32'(beat_count), 32'(mon_e.beats));
        check_eq("error",      32'(error),      32'(mon_e.err));
        check_eq("latency",    32'(cyc),        32'(mon_e.due));
        check_eq("busy_at_valid", 32'(busy),    32'd1);
      end
    end
  end

  task automatic send_alt(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] i0, input logic [7:0] i1, input int n);
    for (int k = 0; k < n; k++) begin
      sample_valid = 1'b1;
      red_sample   = (k % 2 == 0) ? r0 : r1;
      ir_sample    = (k % 2 == 0) ? i0 : i1;
      @(posedge CLK);
      #1;
    end
    sample_valid = 1'b0;
  endtask

  // called right after the last sample of a window was clocked in
  task automatic expect_win(input logic [15:0] r, input logic [7:0] acr, input logic [7:0] dcr,
                            input logic [7:0] aci, input logic [7:0] dci,
                            input logic [3:0] beats, input logic err);
    exp_t e;
    e.ratio = r;   e.acr = acr; e.dcr = dcr; e.aci = aci; e.dci = dci;
    e.beats = beats; e.err = err;
    e.due   = cyc + (err ? 1 : 25);
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check_eq("ready_timeout", 32'(sb.size()) + 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ratio"},       32'(ratio),       32'd0);
    check_eq({tag, "_ratio_valid"}, 32'(ratio_valid), 32'd0);
    check_eq({tag, "_ac_red"},      32'(ac_red),      32'd0);
    check_eq({tag, "_ac_ir"},       32'(ac_ir),       32'd0);
    check_eq({tag, "_dc_red"},      32'(dc_red),      32'd0);
    check_eq({tag, "_dc_ir"},       32'(dc_ir),       32'd0);
    check_eq({tag, "_beat_count"},  32'(beat_count),  32'd0);
    check_eq({tag, "_error"},       32'(error),       32'd0);
    check_eq({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    red_sample = 8'd0; ir_sample = 8'd0;
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    @(negedge CLK);
    check_reset_outs("por");
    enable = 1'b1;
    @(posedge CLK); #1;

    // nominal window, threshold 128 -> no beats
    send_alt(8'd90, 8'd110, 8'd80, 8'd120, 128);
    expect_win(16'h0080, 8'd20, 8'd100, 8'd40, 8'd100, 4'd0, 1'b0);
    wait_ready();

    // same again, threshold 100 -> 64 crossings saturate to 15
    send_alt(8'd90, 8'd110, 8'd80, 8'd120, 128);
    expect_win(16'h0080, 8'd20, 8'd100, 8'd40, 8'd100, 4'd15, 1'b0);
    wait_ready();

    // flat input -> zero AC error path
    send_alt(8'd100, 8'd100, 8'd100, 8'd100, 128);
    expect_win(16'hFFFF, 8'd0, 8'd100, 8'd0, 8'd100, 4'd0, 1'b1);
    wait_ready();

    // full-scale red, IR AC exactly at the minimum
    send_alt(8'd0, 8'd255, 8'd98, 8'd102, 128);
    expect_win(16'h3232, 8'd255, 8'd127, 8'd4, 8'd100, 4'd15, 1'b0);
    wait_ready();

    // samples offered during PRODUCT/DIVIDE/DONE must be dropped
    send_alt(8'd90, 8'd110, 8'd80, 8'd120, 128);
    expect_win(16'h0080, 8'd20, 8'd100, 8'd40, 8'd100, 4'd15, 1'b0);
    send_alt(8'd255, 8'd255, 8'd255, 8'd255, 26);
    send_alt(8'd50, 8'd70, 8'd80, 8'd120, 128);
    expect_win(16'h00D5, 8'd20, 8'd60, 8'd40, 8'd100, 4'd15, 1'b0);
    wait_ready();

    // reset asserted in the middle of the division
    send_alt(8'd90, 8'd110, 8'd80, 8'd120, 128);
    repeat (9) @(posedge CLK);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    @(negedge CLK);
    check_reset_outs("mid_div_rst");
    @(posedge CLK); #1;
    send_alt(8'd90, 8'd110, 8'd80, 8'd120, 128);
    expect_win(16'h0080, 8'd20, 8'd100, 8'd40, 8'd100, 4'd0, 1'b0);
    wait_ready();

    // enable dropped part-way through a window
    send_alt(8'd255, 8'd255, 8'd255, 8'd255, 50);
    enable = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("hold_ratio",  32'(ratio),      32'h0080);
    check_eq("hold_dc_red", 32'(dc_red),     32'd100);
    check_eq("hold_ac_ir",  32'(ac_ir),      32'd40);
    check_eq("idle_busy",   32'(busy),       32'd0);
    enable = 1'b1;
    @(posedge CLK); #1;
    send_alt(8'd90, 8'd110, 8'd80, 8'd120, 128);
    expect_win(16'h0080, 8'd20, 8'd100, 8'd40, 8'd100, 4'd0, 1'b0);
    wait_ready();

    repeat (40) @(posedge CLK);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spo2_ratio_calc.md
SPO2_RATIO_CALC -- requirements
Module: spo2_ratio_calc

Interface
REQ-001 Parameter WIN_LOG2, default 7, meaning log2 of samples per analysis window (128 samples).
REQ-002 Parameter MIN_AC, default 4, meaning the minimum peak-to-peak code a channel needs to be considered valid.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  high once front-end settings are locked; low forces IDLE.
REQ-006 sample_valid  input  1  one-cycle strobe; red_sample/ir_sample hold a new pair.
REQ-007 red_sample  input  8  RED channel ADC code.
REQ-008 ir_sample  input  8  IR channel ADC code.
REQ-009 ratio  output  16  R = (AC_red*DC_ir)/(AC_ir*DC_red), unsigned Q8.8.
REQ-010 ratio_valid  output  1  one-cycle strobe; ratio, ac_*, dc_*, beat_count, error are updated in the same cycle.
REQ-011 ac_red, ac_ir  output  8 each  window max minus min per channel.
REQ-012 dc_red, dc_ir  output  8 each  window sum >> WIN_LOG2 per channel.
REQ-013 beat_count  output  4  IR rising threshold crossings in the window, saturating at 15.
REQ-014 error  output  1  window result invalid (low AC or zero denominator).
REQ-015 busy  output  1  high in PRODUCT, DIVIDE and DONE.

Function
REQ-016 States: IDLE, ACCUM, PRODUCT, DIVIDE, DONE.
REQ-017 IDLE->ACCUM when enable=1; from any state, enable=0 returns to IDLE on the next edge, clearing accumulators without ratio_valid.
REQ-018 ACCUM: on each sample_valid, add each sample to its 15-bit sum, update per-channel min (init 255) and max (init 0), and increment the sample counter.
REQ-019 ACCUM->PRODUCT on the cycle the 2^WIN_LOG2-th sample is accepted (cycle T).
REQ-020 PRODUCT (T+1): compute AC and DC, num = AC_red*DC_ir (16 bit), den = AC_ir*DC_red (16 bit).
REQ-021 If AC_red<MIN_AC, AC_ir<MIN_AC, or den=0, go to DONE with error=1 and ratio=0xFFFF.
REQ-022 Otherwise DIVIDE: compute (num<<8)/den as an unsigned 24-bit restoring division taking exactly 24 cycles (T+2..T+25).
REQ-023 Quotient above 0xFFFF saturates to 0xFFFF with error=0; the fraction is truncated.
REQ-024 DONE: assert ratio_valid for one cycle (T+26 normal path, T+2 error path), then ACCUM with all accumulators cleared.
REQ-025 sample_valid while busy=1 is ignored; the next window starts with the first sample after DONE.
REQ-026 Beat detection: with thr = previous window's dc_ir (128 after reset or IDLE), count a beat when the previous accepted IR sample < thr and the current one >= thr; the first sample of a window has no predecessor.
REQ-027 Outputs hold their values between ratio_valid strobes.

Reset
REQ-028 On rst_n low: state=IDLE; ratio=0; ac_*, dc_*=0; beat_count=0; error=0; ratio_valid=0; busy=0; thr=128; min=255; max=0; sums and counter=0.
REQ-029 Reset mid-DIVIDE aborts the division and emits no ratio_valid.

Structure
REQ-030 A shared package holds the state encoding, the default WIN_LOG2/MIN_AC values, and the Q8.8 fraction-bit constant (8).
REQ-031 The divider is a sub-module seq_divider with inputs start, dividend[23:0] and divisor[15:0], and outputs quotient[23:0] and done, taking 24 cycles.

Verification
REQ-032 Inputs red 90/110 alternating, IR 80/120 alternating, 128 samples -> ac_red=20, dc_red=100, ac_ir=40, dc_ir=100, ratio=0x0080, error=0, beat_count=0, ratio_valid exactly 26 cycles after the last sample.
REQ-033 Repeat that stimulus for a second window (thr=100) -> 64 crossings, so beat_count=15 (saturated) and ratio=0x0080.
REQ-034 Constant red=100, ir=100 -> ac=0, dc=100, error=1, ratio=0xFFFF, ratio_valid at T+2.
REQ-035 Red 0/255 alternating, IR 98/102 alternating -> dc_red=127, ac_red=255, dc_ir=100, ac_ir=4, ratio=0x3232.
REQ-036 rst_n pulsed low at T+10 and enable dropped in ACCUM, in separate runs -> no ratio_valid, all outputs at reset values (reset run only), next window starts from a zero count.
REQ-037 sample_valid every cycle during DIVIDE -> samples ignored; the next window's dc equals that of samples applied only after DONE.
